// File: rtl/variable_pkg.sv
// Shared types and default playfield geometry for the projectile engine and
// the drawing/HUD blocks around it.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  typedef enum logic [1:0] {
    MISS   = 2'd0,
    WALL   = 2'd1,
    GRAZE  = 2'd2,
    DIRECT = 2'd3
  } hit_result_t;

  typedef enum logic [1:0] {
    IDLE,
    FLIGHT,
    IMPACT,
    GAME_OVER
  } proj_state_t;

  localparam int DEF_HP_INIT    = 100;
  localparam int DEF_SCREEN_W   = 1024;
  localparam int DEF_GROUND_Y   = 455;
  localparam int DEF_WALL_X0    = 497;
  localparam int DEF_WALL_X1    = 527;
  localparam int DEF_WALL_Y     = 384;
  localparam int DEF_P1_X0      = 262;
  localparam int DEF_P2_X0      = 712;
  localparam int DEF_P1_ZONE_LO = 112;
  localparam int DEF_P1_ZONE_HI = 262;
  localparam int DEF_P1_CORE_LO = 162;
  localparam int DEF_P1_CORE_HI = 212;
  localparam int DEF_P2_ZONE_LO = 712;
  localparam int DEF_P2_ZONE_HI = 862;
  localparam int DEF_P2_CORE_LO = 762;
  localparam int DEF_P2_CORE_HI = 812;
  localparam int DEF_DMG_GRAZE  = 10;
  localparam int DEF_DMG_DIRECT = 30;

  // y shown while nothing is in the air (below the visible playfield)
  localparam int RESET_Y = 768;

  function automatic logic in_range(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock into horizontal-step ticks; clr restarts the
// period so the first step lands exactly DIV cycles after a launch.
module tick_prescaler #(
  parameter int DIV = 100000
) (
  input  logic clk60MHz,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/projectile_engine.sv
// One-projectile-per-turn flight, impact classification and HP bookkeeping,
// sitting between the trajectory logic and the drawing/HUD blocks.
module projectile_engine
  import variable_pkg::*;
#(
  parameter int HP_INIT    = DEF_HP_INIT,
  parameter int HP_W       = 7,
  parameter int POS_W      = 12,
  parameter int TICK_DIV   = 100000,
  parameter int SCREEN_W   = DEF_SCREEN_W,
  parameter int GROUND_Y   = DEF_GROUND_Y,
  parameter int WALL_X0    = DEF_WALL_X0,
  parameter int WALL_X1    = DEF_WALL_X1,
  parameter int WALL_Y     = DEF_WALL_Y,
  parameter int P1_X0      = DEF_P1_X0,
  parameter int P2_X0      = DEF_P2_X0,
  parameter int P1_ZONE_LO = DEF_P1_ZONE_LO,
  parameter int P1_ZONE_HI = DEF_P1_ZONE_HI,
  parameter int P1_CORE_LO = DEF_P1_CORE_LO,
  parameter int P1_CORE_HI = DEF_P1_CORE_HI,
  parameter int P2_ZONE_LO = DEF_P2_ZONE_LO,
  parameter int P2_ZONE_HI = DEF_P2_ZONE_HI,
  parameter int P2_CORE_LO = DEF_P2_CORE_LO,
  parameter int P2_CORE_HI = DEF_P2_CORE_HI,
  parameter int DMG_GRAZE  = DEF_DMG_GRAZE,
  parameter int DMG_DIRECT = DEF_DMG_DIRECT
) (
  input  logic             clk60MHz,
  input  logic             rst,
  input  logic             throw_start,
  input  logic             turn,
  input  logic [POS_W-1:0] ypos_in,
  input  logic [4:0]       speed,
  input  logic [3:0]       wind,
  output logic [HP_W-1:0]  hp_player1,
  output logic [HP_W-1:0]  hp_player2,
  output logic [POS_W-1:0] xpos_particle,
  output logic [POS_W-1:0] ypos_particle,
  output logic             end_throw,
  output hit_result_t      hit_result,
  output logic             game_over,
  output logic             winner
);

  localparam int SW     = POS_W + 1;
  localparam int PARK_X = SCREEN_W + 1;

  proj_state_t state;
  logic        wall_exit;
  logic        forced_miss;
  logic        launch;
  logic        in_flight;
  logic        tick;

  logic signed [SW-1:0] speed_s, wind_s, eff_raw, eff, x_s, x_step;
  logic                 off_screen, hit_ground, hit_wall;
  logic                 target_p2, in_core, in_zone;
  hit_result_t          cls;
  logic [HP_W-1:0]      dmg, hp_target, hp_new;

  assign launch    = (state == IDLE) && throw_start;
  assign in_flight = (state == FLIGHT);

  tick_prescaler #(.DIV(TICK_DIV)) u_tick (
    .clk60MHz (clk60MHz),
    .rst      (rst),
    .clr      (launch),
    .en       (in_flight),
    .tick     (tick)
  );

  // P1 throws rightwards and P2 leftwards; wind is signed so a strong
  // headwind can cancel the throw entirely (eff clamps at zero).
  always_comb begin
    speed_s    = SW'(speed);
    wind_s     = SW'($signed(wind));
    eff_raw    = (turn == PLAYER_1) ? (speed_s + wind_s) : (speed_s - wind_s);
    eff        = eff_raw[SW-1] ? '0 : eff_raw;
    x_s        = $signed({1'b0, xpos_particle});
    x_step     = (turn == PLAYER_1) ? (x_s + eff) : (x_s - eff);
    off_screen = x_step[SW-1] || (x_step > SW'(SCREEN_W - 1));
    hit_ground = int'(ypos_particle) >= GROUND_Y;
    hit_wall   = in_range(int'(xpos_particle), WALL_X0, WALL_X1) &&
                 (int'(ypos_particle) >= WALL_Y);
  end

  // The thrower's opponent is the target; a wall stop or an off-screen exit
  // overrides any zone the parked x might happen to fall in.
  always_comb begin
    target_p2 = (turn == PLAYER_1);
    if (target_p2) begin
      in_core = in_range(int'(xpos_particle), P2_CORE_LO, P2_CORE_HI);
      in_zone = in_range(int'(xpos_particle), P2_ZONE_LO, P2_ZONE_HI);
    end else begin
      in_core = in_range(int'(xpos_particle), P1_CORE_LO, P1_CORE_HI);
      in_zone = in_range(int'(xpos_particle), P1_ZONE_LO, P1_ZONE_HI);
    end
    if (wall_exit)        cls = WALL;
    else if (forced_miss) cls = MISS;
    else if (in_core)     cls = DIRECT;
    else if (in_zone)     cls = GRAZE;
    else                  cls = MISS;
    case (cls)
      DIRECT:  dmg = HP_W'(DMG_DIRECT);
      GRAZE:   dmg = HP_W'(DMG_GRAZE);
      default: dmg = '0;
    endcase
    hp_target = target_p2 ? hp_player2 : hp_player1;
    hp_new    = (hp_target > dmg) ? (hp_target - dmg) : '0;
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      xpos_particle <= POS_W'(PARK_X);
      hp_player1    <= HP_W'(HP_INIT);
      hp_player2    <= HP_W'(HP_INIT);
      end_throw     <= 1'b0;
      hit_result    <= MISS;
      game_over     <= 1'b0;
      winner        <= 1'b0;
      wall_exit     <= 1'b0;
      forced_miss   <= 1'b0;
    end else begin
      end_throw <= 1'b0;
      case (state)
        IDLE: begin
          if (throw_start) begin
            state         <= FLIGHT;
            xpos_particle <= (turn == PLAYER_1) ? POS_W'(P1_X0) : POS_W'(P2_X0);
            wall_exit     <= 1'b0;
            forced_miss   <= 1'b0;
          end else begin
            xpos_particle <= POS_W'(PARK_X);
          end
        end
        FLIGHT: begin
          if (hit_ground) begin
            state <= IMPACT;
          end else if (hit_wall) begin
            state     <= IMPACT;
            wall_exit <= 1'b1;
          end else if (off_screen) begin
            state       <= IMPACT;
            forced_miss <= 1'b1;
          end else if (tick) begin
            xpos_particle <= x_step[POS_W-1:0];
          end
        end
        IMPACT: begin
          end_throw     <= 1'b1;
          hit_result    <= cls;
          xpos_particle <= POS_W'(PARK_X);
          if (target_p2) hp_player2 <= hp_new;
          else           hp_player1 <= hp_new;
          if (hp_new == '0) begin
            state     <= GAME_OVER;
            game_over <= 1'b1;
            winner    <= turn;
          end else begin
            state <= IDLE;
          end
        end
        GAME_OVER: begin
          xpos_particle <= POS_W'(PARK_X);
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk60MHz or posedge rst) begin
    if (rst) ypos_particle <= POS_W'(RESET_Y);
    else     ypos_particle <= ypos_in;
  end

endmodule

// File: tb/tb_projectile_engine.sv
// Directed scenarios for projectile_engine; each expected throw outcome is
// queued up front and matched against the DUT at every end_throw pulse.
module tb_projectile_engine;
  import variable_pkg::*;

  logic        clk60MHz = 1'b0;
  logic        rst;
  logic        throw_start;
  logic        turn;
  logic [11:0] ypos_in;
  logic [4:0]  speed;
  logic [3:0]  wind;
  logic [6:0]  hp_player1, hp_player2;
  logic [11:0] xpos_particle, ypos_particle;
  logic        end_throw;
  hit_result_t hit_result;
  logic        game_over;
  logic        winner;

  typedef struct {
    hit_result_t res;
    int          hp1;
    int          hp2;
    int          go;
    int          win;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;
  int   pulses = 0;
  int   expected_pulses = 0;

  int p1_tgt[4] = '{762, 787, 812, 762};
  int p2_tgt[4] = '{212, 187, 162, 212};
  int hp_seq[4] = '{70, 40, 10, 0};

  projectile_engine #(.TICK_DIV(4)) dut (
    .clk60MHz      (clk60MHz),
    .rst           (rst),
    .throw_start   (throw_start),
    .turn          (turn),
    .ypos_in       (ypos_in),
    .speed         (speed),
    .wind          (wind),
    .hp_player1    (hp_player1),
    .hp_player2    (hp_player2),
    .xpos_particle (xpos_particle),
    .ypos_particle (ypos_particle),
    .end_throw     (end_throw),
    .hit_result    (hit_result),
    .game_over     (game_over),
    .winner        (winner)
  );

  always #5 clk60MHz = ~clk60MHz;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic pushExpected(input hit_result_t res, input int hp1, input int hp2,
                              input int go, input int win);
    exp_t e;
    e.res = res; e.hp1 = hp1; e.hp2 = hp2; e.go = go; e.win = win;
    sb.push_back(e);
    expected_pulses++;
  endtask

  // Sets up a throw and launches it; returns at the negedge after launch.
  task automatic applyStimulus(input logic t, input int spd, input int wnd, input int y);
    @(negedge clk60MHz);
    turn    = t;
    speed   = 5'(spd);
    wind    = 4'(wnd);
    ypos_in = 12'(y);
    repeat (2) @(negedge clk60MHz);
    throw_start = 1'b1;
    @(negedge clk60MHz);
    throw_start = 1'b0;
    checkOutput("launch x", int'(xpos_particle), (t == PLAYER_1) ? 262 : 712);
  endtask

  task automatic waitForX(input int target);
    int n;
    n = 0;
    while (int'(xpos_particle) != target && n < 1000) begin
      @(negedge clk60MHz);
      n++;
    end
    checkOutput("reach x", int'(xpos_particle), target);
  endtask

  task automatic waitEndThrow(input int limit);
    int n;
    n = 0;
    while (!end_throw && n < limit) begin
      @(negedge clk60MHz);
      n++;
    end
    checkOutput("end_throw seen", int'(end_throw), 1);
  endtask

  task automatic hitAt(input int target, input int y, input hit_result_t res,
                       input int hp1, input int hp2, input int go, input int win);
    waitForX(target);
    pushExpected(res, hp1, hp2, go, win);
    ypos_in = 12'(y);
    waitEndThrow(10);
  endtask

  always @(negedge clk60MHz) begin : monitor
    exp_t e;
    if (!rst && end_throw) begin
      pulses++;
      if (sb.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected end_throw: got pulse with hit_result %0d, expected none",
                 int'(hit_result));
      end else begin
        e = sb.pop_front();
        checkOutput("hit_result", int'(hit_result), int'(e.res));
        checkOutput("hp_player1", int'(hp_player1), e.hp1);
        checkOutput("hp_player2", int'(hp_player2), e.hp2);
        checkOutput("game_over", int'(game_over), e.go);
        if (e.go != 0) checkOutput("winner", int'(winner), e.win);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: still running at %0t, limit 500000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int max_x, last_x, n;
    rst = 1'b1; throw_start = 1'b0; turn = PLAYER_1;
    ypos_in = 12'd100; speed = 5'd0; wind = 4'd0;
    repeat (3) @(negedge clk60MHz);
    checkOutput("reset hp_player1", int'(hp_player1), 100);
    checkOutput("reset hp_player2", int'(hp_player2), 100);
    checkOutput("reset xpos", int'(xpos_particle), 1025);
    checkOutput("reset ypos", int'(ypos_particle), 768);
    checkOutput("reset end_throw", int'(end_throw), 0);
    checkOutput("reset hit_result", int'(hit_result), int'(MISS));
    checkOutput("reset game_over", int'(game_over), 0);
    checkOutput("reset winner", int'(winner), 0);
    rst = 1'b0;

    $display("[TB] P1 direct hit, speed 10");
    applyStimulus(PLAYER_1, 10, 0, 100);
    hitAt(782, 500, DIRECT, 100, 70, 0, 0);

    $display("[TB] P2 graze, speed 5 wind +2");
    applyStimulus(PLAYER_2, 5, 2, 100);
    repeat (3) @(negedge clk60MHz);
    checkOutput("x before first step", int'(xpos_particle), 712);
    @(negedge clk60MHz);
    checkOutput("x after first step", int'(xpos_particle), 709);
    repeat (4) @(negedge clk60MHz);
    checkOutput("x after second step", int'(xpos_particle), 706);
    hitAt(232, 500, GRAZE, 90, 70, 0, 0);

    $display("[TB] wall stop at x 500");
    pushExpected(WALL, 90, 70, 0, 0);
    applyStimulus(PLAYER_1, 14, 0, 400);
    waitEndThrow(200);

    $display("[TB] ground beats wall");
    applyStimulus(PLAYER_1, 14, 0, 100);
    hitAt(500, 460, MISS, 90, 70, 0, 0);

    $display("[TB] off-screen exit, speed 31 wind +7");
    pushExpected(MISS, 90, 70, 0, 0);
    applyStimulus(PLAYER_1, 31, 7, 100);
    max_x = 0; last_x = 0; n = 0;
    while (!end_throw && n < 300) begin
      last_x = int'(xpos_particle);
      if (last_x > max_x) max_x = last_x;
      @(negedge clk60MHz);
      n++;
    end
    checkOutput("end_throw off-screen", int'(end_throw), 1);
    checkOutput("last x in flight", last_x, 1022);
    checkOutput("max x in flight", max_x, 1022);

    $display("[TB] zero effective speed");
    applyStimulus(PLAYER_1, 2, -5, 100);
    repeat (12) @(negedge clk60MHz);
    checkOutput("eff0 x static", int'(xpos_particle), 262);
    hitAt(262, 460, MISS, 90, 70, 0, 0);

    $display("[TB] async reset mid-flight");
    applyStimulus(PLAYER_1, 10, 0, 100);
    repeat (6) @(negedge clk60MHz);
    @(posedge clk60MHz);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid rst xpos", int'(xpos_particle), 1025);
    checkOutput("mid rst ypos", int'(ypos_particle), 768);
    checkOutput("mid rst hp_player1", int'(hp_player1), 100);
    checkOutput("mid rst hp_player2", int'(hp_player2), 100);
    checkOutput("mid rst end_throw", int'(end_throw), 0);
    @(negedge clk60MHz);
    rst = 1'b0;
    repeat (10) @(negedge clk60MHz);
    checkOutput("post rst x parked", int'(xpos_particle), 1025);
    checkOutput("post rst end_throw", int'(end_throw), 0);

    $display("[TB] P1 wins by saturating damage");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(PLAYER_1, 25, 0, 100);
      hitAt(p1_tgt[i], 500, DIRECT, 100, hp_seq[i], (i == 3) ? 1 : 0, 0);
    end
    @(negedge clk60MHz);
    throw_start = 1'b1;
    repeat (10) @(negedge clk60MHz);
    throw_start = 1'b0;
    checkOutput("game over x parked", int'(xpos_particle), 1025);
    checkOutput("game over sticky", int'(game_over), 1);
    checkOutput("game over hp_player2", int'(hp_player2), 0);
    checkOutput("game over hp_player1", int'(hp_player1), 100);

    $display("[TB] reset, then P2 wins");
    rst = 1'b1;
    @(negedge clk60MHz);
    rst = 1'b0;
    checkOutput("game_over cleared", int'(game_over), 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(PLAYER_2, 25, 0, 100);
      hitAt(p2_tgt[i], 500, DIRECT, hp_seq[i], 100, (i == 3) ? 1 : 0, 1);
    end

    repeat (5) @(negedge clk60MHz);
    checkOutput("end_throw pulses", pulses, expected_pulses);
    checkOutput("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
